ifclocks_divbank: RTL and testbench

Runtime-programmable divided-clock bank: from one reference clock it generates NCLK phase-aligned divided clocks, each with a one-cycle rising-edge strobe, plus a `locked` status. It is the synthesisable, reconfigurable successor to the fixed PLL clock set in the ifclocks family. Divisors reload from a small config port without a full reset, and every channel is re-aligned to a common phase whenever a new divisor set is applied.

---
 rtl/ifclocks_divbank.sv | 132 +++++++++++++
 tb/tb_ifclocks_divbank.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ifclocks_divbank.sv
// rtl/ifclocks_divbank.sv - runtime-programmable bank of phase-aligned divided clocks
module ifclocks_divbank #(
  parameter int                   NCLK        = 4,
  parameter int                   DIVW        = 8,
  parameter logic [NCLK*DIVW-1:0] DIV_INIT    = {8'd20, 8'd16, 8'd2, 8'd1},
  parameter int                   LOCK_CYCLES = 16,
  localparam int                  SELW        = (NCLK > 1) ? $clog2(NCLK) : 1
) (
  input  logic            refclk,
  input  logic            rst,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [SELW-1:0] cfg_sel,
  input  logic [DIVW-1:0] cfg_div,
  input  logic            cfg_apply,
  output logic [NCLK-1:0] outclk,
  output logic [NCLK-1:0] stb,
  output logic            locked
);

  localparam int LCW = $clog2(LOCK_CYCLES + 1);

  logic [DIVW-1:0] shadow_q [NCLK];
  logic [DIVW-1:0] shadow_d [NCLK];
  logic [DIVW-1:0] active_q [NCLK];
  logic [DIVW-1:0] active_d [NCLK];
  logic [DIVW-1:0] cnt_q    [NCLK];
  logic [DIVW-1:0] cnt_d    [NCLK];
  logic [DIVW:0]   half     [NCLK];
  logic [NCLK-1:0] outclk_q, outclk_d;
  logic [NCLK-1:0] stb_q, stb_d;
  logic [LCW-1:0]  lock_cnt_q, lock_cnt_d;
  logic            locked_q, locked_d;
  // running_q is clear for exactly one edge after reset release, so that the
  // release edge shows all-low outputs and every channel rises on the edge after.
  logic            running_q, running_d;
  logic            accept;
  logic            do_apply;

  // Next-state: config writes, apply (soft re-align), channel counters, lock count
  always_comb begin
    accept     = cfg_valid && locked_q;
    do_apply   = accept && cfg_apply;
    shadow_d   = shadow_q;
    active_d   = active_q;
    cnt_d      = cnt_q;
    outclk_d   = outclk_q;
    stb_d      = stb_q;
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    running_d  = running_q;

    for (int i = 0; i < NCLK; i++) begin
      half[i] = ({1'b0, active_q[i]} + (DIVW+1)'(1)) >> 1;
      // An out-of-range cfg_sel matches no channel, so the write is dropped.
      if (accept && (SELW'(i) == cfg_sel)) begin
        shadow_d[i] = cfg_div;
      end
    end

    if (do_apply) begin
      // Apply doubles as the release edge: outputs low now, first rise next edge.
      for (int i = 0; i < NCLK; i++) begin
        active_d[i] = shadow_d[i];
        cnt_d[i]    = '0;
      end
      outclk_d   = '0;
      stb_d      = '0;
      locked_d   = 1'b0;
      lock_cnt_d = '0;
      running_d  = 1'b1;
    end else if (!running_q) begin
      running_d = 1'b1;
    end else begin
      for (int i = 0; i < NCLK; i++) begin
        if (active_q[i] == '0) begin
          cnt_d[i]    = '0;
          outclk_d[i] = 1'b0;
          stb_d[i]    = 1'b0;
        end else begin
          outclk_d[i] = ({1'b0, cnt_q[i]} < half[i]);
          stb_d[i]    = (cnt_q[i] == '0);
          // Divisor 1 wraps every cycle, which yields a constant-high output.
          if (cnt_q[i] == active_q[i] - DIVW'(1)) begin
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + DIVW'(1);
          end
        end
      end
      if (!locked_q) begin
        if (lock_cnt_q == LCW'(LOCK_CYCLES - 1)) begin
          locked_d   = 1'b1;
          lock_cnt_d = LCW'(LOCK_CYCLES);
        end else begin
          lock_cnt_d = lock_cnt_q + LCW'(1);
        end
      end
    end
  end

  // State register; reset restores the power-on divisor set in both banks
  always_ff @(posedge refclk) begin
    if (rst) begin
      for (int i = 0; i < NCLK; i++) begin
        shadow_q[i] <= DIV_INIT[i*DIVW +: DIVW];
        active_q[i] <= DIV_INIT[i*DIVW +: DIVW];
        cnt_q[i]    <= '0;
      end
      outclk_q   <= '0;
      stb_q      <= '0;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      cnt_q      <= cnt_d;
      outclk_q   <= outclk_d;
      stb_q      <= stb_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
      running_q  <= running_d;
    end
  end

  assign outclk    = outclk_q;
  assign stb       = stb_q;
  assign locked    = locked_q;
  assign cfg_ready = locked_q;

endmodule

// File: tb/tb_ifclocks_divbank.sv
// tb/tb_ifclocks_divbank.sv - scoreboard bench for ifclocks_divbank
module tb_ifclocks_divbank;

  localparam int NCLK = 5;
  localparam int DIVW = 8;
  localparam int LC   = 16;
  localparam int SELW = 3;
  localparam logic [NCLK*DIVW-1:0] INIT = {8'd3, 8'd20, 8'd16, 8'd2, 8'd1};

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cfg_valid = 1'b0;
  logic            cfg_ready;
  logic [SELW-1:0] cfg_sel = '0;
  logic [DIVW-1:0] cfg_div = '0;
  logic            cfg_apply = 1'b0;
  logic [NCLK-1:0] outclk, stb;
  logic            locked;

  ifclocks_divbank #(
    .NCLK(NCLK), .DIVW(DIVW), .DIV_INIT(INIT), .LOCK_CYCLES(LC)
  ) dut (
    .refclk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_sel(cfg_sel), .cfg_div(cfg_div), .cfg_apply(cfg_apply),
    .outclk(outclk), .stb(stb), .locked(locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NCLK-1:0] oc;
    logic [NCLK-1:0] st;
    logic            lk;
  } exp_t;

  typedef struct {
    logic                 v;
    logic [SELW-1:0]      s;
    logic [DIVW-1:0]      d;
    logic                 a;
    logic [NCLK*DIVW-1:0] ediv;
    int                   hold;
  } vec_t;

  exp_t sb[$];
  exp_t last_exp;
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: phase t counts edges since the last release point
  int                   t = -1;
  logic [NCLK*DIVW-1:0] m_div = INIT;
  logic                 m_locked = 1'b0;
  logic                 last_acc = 1'b0;

  task automatic drive(input logic r, input logic v, input logic [SELW-1:0] s,
                       input logic [DIVW-1:0] d, input logic a,
                       input logic [NCLK*DIVW-1:0] nd);
    exp_t e;
    @(negedge clk);
    rst = r; cfg_valid = v; cfg_sel = s; cfg_div = d; cfg_apply = a;
    if (r) begin
      t = -1;
      m_div = INIT;
      last_acc = 1'b0;
    end else begin
      last_acc = v && m_locked;
      if (last_acc && a) begin
        m_div = nd;
        t = 0;
      end else begin
        t++;
      end
    end
    for (int i = 0; i < NCLK; i++) begin
      int dv;
      int k;
      dv = int'(m_div[i*DIVW +: DIVW]);
      if (r || t == 0 || dv == 0) begin
        e.oc[i] = 1'b0;
        e.st[i] = 1'b0;
      end else begin
        k = (t - 1) % dv;
        e.oc[i] = (k < (dv + 1) / 2);
        e.st[i] = (k == 0);
      end
    end
    e.lk = !r && (t >= LC);
    m_locked = e.lk;
    last_exp = e;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) drive(1'b0, 1'b0, '0, '0, 1'b0, m_div);
  endtask

  // Monitor: compare each DUT output sample against the oldest expectation
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      if ({outclk, stb, locked, cfg_ready} !== {e.oc, e.st, e.lk, e.lk}) begin
        miscompares++;
        $display("FAIL vec%0d out/stb/lock/rdy: got %b %b %b %b, exp %b %b %b %b",
                 vectors, outclk, stb, locked, cfg_ready, e.oc, e.st, e.lk, e.lk);
      end
    end
  end

  vec_t tbl [8];

  initial begin
    int n_acc;
    tbl[0] = '{1'b1, 3'd2, 8'd5, 1'b1, {8'd3, 8'd20, 8'd5, 8'd2, 8'd1}, 30};
    tbl[1] = '{1'b1, 3'd3, 8'd4, 1'b0, {8'd3, 8'd20, 8'd5, 8'd2, 8'd1}, 45};
    tbl[2] = '{1'b1, 3'd0, 8'd3, 1'b1, {8'd3, 8'd4,  8'd5, 8'd2, 8'd3}, 25};
    tbl[3] = '{1'b1, 3'd1, 8'd0, 1'b1, {8'd3, 8'd4,  8'd5, 8'd0, 8'd3}, 25};
    tbl[4] = '{1'b1, 3'd5, 8'd9, 1'b1, {8'd3, 8'd4,  8'd5, 8'd0, 8'd3}, 20};
    tbl[5] = '{1'b1, 3'd7, 8'd9, 1'b0, {8'd3, 8'd4,  8'd5, 8'd0, 8'd3}, 3};
    tbl[6] = '{1'b1, 3'd4, 8'd7, 1'b0, {8'd3, 8'd4,  8'd5, 8'd0, 8'd3}, 3};
    tbl[7] = '{1'b1, 3'd6, 8'd1, 1'b1, {8'd7, 8'd4,  8'd5, 8'd0, 8'd3}, 25};

    // Reset defaults, then first lock
    repeat (3) drive(1'b1, 1'b0, '0, '0, 1'b0, INIT);
    idle(45);

    for (int j = 0; j < 8; j++) begin
      drive(1'b0, tbl[j].v, tbl[j].s, tbl[j].d, tbl[j].a, tbl[j].ediv);
      idle(tbl[j].hold);
    end

    // Handshake: valid held through the lock window, one more accept at ready
    n_acc = 0;
    for (int c = 0; c < 40 && n_acc < 2; c++) begin
      drive(1'b0, 1'b1, 3'd5, 8'd0, 1'b1, m_div);
      if (last_acc) n_acc++;
    end
    if (n_acc < 2) begin
      vectors++;
      miscompares++;
      $display("FAIL handshake_bound: got %0d accepts, exp 2", n_acc);
    end
    idle(20);

    // Reset during a ch3 high phase
    for (int c = 0; c < 10 && !last_exp.oc[3]; c++) idle(1);
    drive(1'b1, 1'b0, '0, '0, 1'b0, INIT);
    idle(8);
    // Reset during the lock count, colliding with an apply request
    drive(1'b1, 1'b1, 3'd2, 8'd9, 1'b1, INIT);
    idle(20);
    // Apply with no real write: divisors must be back at their reset values
    drive(1'b0, 1'b1, 3'd5, 8'd0, 1'b1, INIT);
    idle(45);

    repeat (2) @(posedge clk);
    #4;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
